// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/capture sequencer in front of the ALU; returns the selected unit's result.
// Optional flag cross-check enabled by defining ALU_SEQ_FLAG_CHECK_EN.
module alu_cmd_sequencer #(
  parameter int ALU_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ALU_WIDTH-1:0]          cmd_a,
  input  logic [ALU_WIDTH-1:0]          cmd_b,
  input  logic [3:0]                    cmd_fun,
  output logic [ALU_WIDTH-1:0]          alu_a,
  output logic [ALU_WIDTH-1:0]          alu_b,
  output logic [3:0]                    alu_fun,
  input  logic [ALU_WIDTH-1:0]          arith_out,
  input  logic [ALU_WIDTH-1:0]          logic_out,
  input  logic [ALU_WIDTH-1:0]          comp_out,
  input  logic [ALU_WIDTH-1:0]          shift_out,
  input  logic                          arith_flag,
  input  logic                          logic_flag,
  input  logic                          comp_flag,
  input  logic                          shift_flag,
  input  logic                          carry_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ALU_WIDTH-1:0]          rsp_data,
  output logic [3:0]                    rsp_fun,
  output logic                          rsp_carry,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    logic [3:0]           fun;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  cmd_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              push, pop, fifo_empty, fifo_full;
  state_t            state, state_nxt;
  logic [ALU_WIDTH-1:0] sel_data;
  logic              flag_err;

  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  // Held low while in reset so nothing is accepted into a FIFO being cleared.
  assign cmd_ready  = rst & ~fifo_full;
  assign push       = cmd_valid & cmd_ready;
  assign fifo_level = level;
  assign busy       = (state != IDLE) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, fun: cmd_fun};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_data = arith_out;
    case (alu_fun[3:2])
      2'b00:   sel_data = arith_out;
      2'b01:   sel_data = logic_out;
      2'b10:   sel_data = comp_out;
      default: sel_data = shift_out;
    endcase
  end

`ifdef ALU_SEQ_FLAG_CHECK_EN
  // Exactly the selected unit's flag must be raised.
  logic [3:0] flags, flags_exp;
  assign flags     = {shift_flag, comp_flag, logic_flag, arith_flag};
  assign flags_exp = 4'b0001 << alu_fun[3:2];
  assign flag_err  = (flags != flags_exp);
`else
  logic unused_flags;
  assign unused_flags = ^{arith_flag, logic_flag, comp_flag, shift_flag};
  assign flag_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fun   <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop) begin
        alu_a   <= mem[rd_ptr].a;
        alu_b   <= mem[rd_ptr].b;
        alu_fun <= mem[rd_ptr].fun;
      end
      if (state == CAPTURE) begin
        rsp_valid <= 1'b1;
        rsp_data  <= sel_data;
        rsp_fun   <= alu_fun;
        rsp_carry <= (alu_fun[3:2] == 2'b00) & carry_out;
        rsp_err   <= flag_err;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side companion to the ALU top level. It accepts operation commands (A, B, 4-bit function) over a valid/ready stream and buffers them in a small FIFO. It issues one command at a time to the ALU's operand and function inputs, then captures the result of the unit selected by the function. It returns that result, with carry and an error indication, over a second valid/ready stream.

## Interface
Parameters:
- ALU_WIDTH, 16, operand/result width; must equal the ALU's alu_width
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_a, cmd_b  in  ALU_WIDTH  operands
- cmd_fun  in  4  [3:2] unit select (00 arith, 01 logic, 10 comp, 11 shift); [1:0] op within unit
- alu_a, alu_b  out  ALU_WIDTH  registered operands to ALU A/B
- alu_fun  out  4  registered function to ALU alu_fun
- arith_out, logic_out, comp_out, shift_out  in  ALU_WIDTH  ALU results
- arith_flag, logic_flag, comp_flag, shift_flag, carry_out  in  1  ALU flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_data  out  ALU_WIDTH  selected result
- rsp_fun  out  4  function of this response
- rsp_carry  out  1  carry_out if arith, else 0
- rsp_err  out  1  flag-check failure (see Configuration)
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Push: cmd_valid && cmd_ready. cmd_ready = (fifo_level != FIFO_DEPTH). No push while full, even if a pop occurs in the same cycle. There is no empty bypass; a command always passes through the FIFO.
- Circular pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop leaves fifo_level unchanged.
- FSM states IDLE, ISSUE, CAPTURE, RESP:
  - IDLE: if FIFO non-empty, pop the head into alu_a/alu_b/alu_fun and go to ISSUE; else stay in IDLE.
  - ISSUE: the ALU samples the operands on this edge. Go to CAPTURE.
  - CAPTURE: ALU outputs are valid. Register rsp_data (mux on alu_fun[3:2]), rsp_fun, rsp_carry and rsp_err. Set rsp_valid. Go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, clear rsp_valid. If the FIFO is non-empty, pop the next command in the same cycle and go to ISSUE; else go to IDLE.
- alu_a/alu_b/alu_fun hold the last issued command between operations.
- Reset (any time, including mid-operation) has these effects:
  - FIFO emptied and pointers zeroed.
  - FSM returns to IDLE.
  - All outputs go to 0, except cmd_ready, which is 1 once rst is deasserted.
  - In-flight commands are discarded; no response is produced for them.

## Timing
- Command accepted at edge N → popped at edge N+1 → ALU samples at N+2 → rsp_valid high after edge N+3. Latency is 3 cycles with an idle FSM.
- Back-to-back throughput with rsp_ready tied high: one response per 3 cycles (RESP→ISSUE→CAPTURE→RESP).
- rsp_ready low stalls the FSM in RESP; the FIFO keeps accepting until full.
- rsp_valid never drops without a handshake, except on reset.

## Configuration
- ALU_SEQ_FLAG_CHECK_EN defined:
  - In CAPTURE, rsp_err = 1 unless the selected unit's flag is 1 and the other three flags are 0.
  - A failing response is still delivered normally.
- Not defined: rsp_err is constant 0 and no flag inputs are used (flag ports remain present).

## Test plan
- Reset, then one command fun=4'b0000 (add), A=16'h0003, B=16'h0004, rsp_ready=1 → rsp_valid 3 cycles after acceptance, rsp_data=16'h0007, rsp_carry=0, rsp_fun=4'b0000, rsp_err=0.
- fun=4'b0000, A=16'hFFFF, B=16'h0001 → rsp_data=16'h0000, rsp_carry=1. Then fun=4'b0100 with the same operands → rsp_carry=0, rsp_data=logic_out.
- rsp_ready held 0; push FIFO_DEPTH+2 commands (0x01..0x06 in A, B=0, add) →
  - one response pending, cmd_ready drops when fifo_level=4.
  - releasing rsp_ready yields responses in order 0x01..0x06, with no loss or duplication.
- Assert rst low for one cycle while in CAPTURE with 2 commands queued → fifo_level=0, rsp_valid=0, alu_* = 0, and no response afterwards.
- With ALU_SEQ_FLAG_CHECK_EN defined, force comp_flag=0 during a fun=4'b1000 capture → rsp_err=1. Without the macro, the same stimulus gives rsp_err=0.
- Push and pop in the same cycle with fifo_level=2 → level stays 2. Push while full with a concurrent pop → push refused (cmd_ready=0).
